// File: rtl/i2c_frame_slave_rx.sv
// Write-only I2C target that receives a 13-byte task frame and publishes opcode/A/B/result.
// Optional glitch filter on SCL/SDA: define I2C_RX_GLITCH_FILTER_EN.
module i2c_frame_slave_rx #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
  parameter int unsigned FRAME_BYTES = 13,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  output logic [1:0]  opcode,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] result,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned FW = FRAME_BYTES * 8;
  localparam int unsigned CW = $clog2(FRAME_BYTES + 2);
  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_BYTES);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] RX_BYTE  = 3'd3;
  localparam logic [2:0] BYTE_ACK = 3'd4;
  localparam logic [2:0] IGNORE   = 3'd5;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_prev, sda_prev;
  logic scl_rise_q, scl_fall_q, start_q, stop_q, sda_bit_q;
  logic [2:0]    state_q;
  logic [2:0]    bit_cnt_q;
  logic [6:0]    byte_q;
  logic [CW-1:0] byte_cnt_q;
  logic [FW-1:0] shift_q;
  logic          overflow_q;
  logic          sda_oe_q;
  logic          frame_good;

  assign i2c_sda = sda_oe_q ? 1'b0 : 1'bz;

  // Synchronisers idle high so reset release never looks like a bus edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
    end
  end

`ifdef I2C_RX_GLITCH_FILTER_EN
  logic       scl_f, sda_f;
  logic [1:0] scl_cnt, sda_cnt;

  // A new level is accepted only after three consecutive samples disagree with the current one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= 2'd0;
      sda_cnt <= 2'd0;
    end else begin
      if (scl_sync[SYNC_STAGES-1] == scl_f) begin
        scl_cnt <= 2'd0;
      end else if (scl_cnt == 2'd2) begin
        scl_f   <= scl_sync[SYNC_STAGES-1];
        scl_cnt <= 2'd0;
      end else begin
        scl_cnt <= scl_cnt + 2'd1;
      end
      if (sda_sync[SYNC_STAGES-1] == sda_f) begin
        sda_cnt <= 2'd0;
      end else if (sda_cnt == 2'd2) begin
        sda_f   <= sda_sync[SYNC_STAGES-1];
        sda_cnt <= 2'd0;
      end else begin
        sda_cnt <= sda_cnt + 2'd1;
      end
    end
  end

  assign scl_s = scl_f;
  assign sda_s = sda_f;
`else
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_prev   <= 1'b1;
      sda_prev   <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_bit_q  <= 1'b1;
    end else begin
      scl_prev   <= scl_s;
      sda_prev   <= sda_s;
      scl_rise_q <= scl_s & ~scl_prev;
      scl_fall_q <= ~scl_s & scl_prev;
      start_q    <= scl_s & scl_prev & sda_prev & ~sda_s;
      stop_q     <= scl_s & scl_prev & ~sda_prev & sda_s;
      sda_bit_q  <= sda_s;
    end
  end

  assign frame_good = (byte_cnt_q == FRAME_CNT) && (shift_q[FW-1 -: 6] == 6'b111111) &&
                      !overflow_q;

  // Bits collect in byte_q and reach shift_q only on the 8th bit, so the SCL rise that
  // precedes a STOP or repeated START cannot disturb the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      byte_q      <= 7'd0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      overflow_q  <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      opcode      <= 2'd0;
      a           <= 32'd0;
      b           <= 32'd0;
      result      <= 32'd0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (start_q) begin
        if (busy && byte_cnt_q != '0) frame_err <= 1'b1;
        busy       <= 1'b0;
        state_q    <= ADDR;
        bit_cnt_q  <= 3'd0;
        byte_cnt_q <= '0;
        shift_q    <= '0;
        overflow_q <= 1'b0;
        sda_oe_q   <= 1'b0;
      end else if (stop_q) begin
        if (busy) begin
          if (frame_good) begin
            frame_valid <= 1'b1;
            opcode      <= shift_q[FW-7 -: 2];
            a           <= shift_q[FW-9 -: 32];
            b           <= shift_q[FW-41 -: 32];
            result      <= shift_q[FW-73 -: 32];
          end else begin
            frame_err <= 1'b1;
          end
        end
        busy     <= 1'b0;
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise_q) begin
              byte_q    <= {byte_q[5:0], sda_bit_q};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (byte_q == SLAVE_ADDR && !sda_bit_q) begin
                  state_q    <= ADDR_ACK;
                  busy       <= 1'b1;
                  byte_cnt_q <= '0;
                end else begin
                  state_q <= IGNORE;
                end
              end
            end
          end
          ADDR_ACK, BYTE_ACK: begin
            if (scl_fall_q) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                state_q   <= RX_BYTE;
                bit_cnt_q <= 3'd0;
              end
            end
          end
          RX_BYTE: begin
            if (scl_rise_q) begin
              byte_q    <= {byte_q[5:0], sda_bit_q};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                shift_q    <= {shift_q[FW-9:0], byte_q, sda_bit_q};
                byte_cnt_q <= byte_cnt_q + 1'b1;
                if (byte_cnt_q < FRAME_CNT) begin
                  state_q <= BYTE_ACK;
                end else begin
                  overflow_q <= 1'b1;
                  state_q    <= IGNORE;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_frame_slave_rx.sv
// Bench for i2c_frame_slave_rx: directed frame table, random frames against a frame-level
// model, plus repeated-START and mid-frame reset sequences.
module tb_i2c_frame_slave_rx;

  localparam int SYNC = 2;

  typedef struct {
    logic [7:0]   addr;
    int           n;
    logic [127:0] d;
    logic [15:0]  exp_ack;
    bit           exp_valid;
    bit           exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  wire         sda;
  logic [1:0]  opcode;
  logic [31:0] a, b, result;
  logic        frame_valid, frame_err, busy;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_frame_slave_rx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i2c_scl     (scl),
    .i2c_sda     (sda),
    .opcode      (opcode),
    .a           (a),
    .b           (b),
    .result      (result),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int valid_cnt, err_cnt, both_cnt, first_valid, stop_cyc;
  bit busy_seen, dut_low_seen;
  logic [103:0] ref_frame = '0;
  vec_t tbl[40];
  int ntbl;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (frame_err) err_cnt++;
    if (frame_valid && frame_err) both_cnt++;
    if (busy) busy_seen = 1'b1;
    if (!m_low && sda === 1'b0) dut_low_seen = 1'b1;
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    if (!scl) begin
      m_low = 1'b0;
      wt(5);
      scl = 1'b1;
      wt(8);
    end
    m_low = 1'b1;
    wt(8);
    scl = 1'b0;
    wt(5);
  endtask

  task automatic send_bit(input bit v);
    m_low = !v;
    wt(5);
    scl = 1'b1;
    wt(8);
    scl = 1'b0;
    wt(5);
  endtask

  task automatic get_ack(output bit ack);
    m_low = 1'b0;
    wt(5);
    scl = 1'b1;
    wt(4);
    ack = (sda === 1'b0);
    wt(4);
    scl = 1'b0;
    wt(5);
  endtask

  task automatic send_byte(input logic [7:0] v, output bit ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    get_ack(ack);
  endtask

  task automatic bus_stop();
    m_low = 1'b1;
    wt(5);
    scl = 1'b1;
    wt(8);
    m_low = 1'b0;
    stop_cyc = cyc;
    wt(12);
  endtask

  task automatic clear_mon();
    valid_cnt = 0;
    err_cnt = 0;
    first_valid = -1;
    busy_seen = 1'b0;
    dut_low_seen = 1'b0;
  endtask

  task automatic send_frame(input vec_t v, output logic [15:0] acks);
    bit ack;
    acks = '0;
    bus_start();
    send_byte(v.addr, ack);
    acks[0] = ack;
    for (int i = 0; i < v.n; i++) begin
      send_byte(v.d[127-8*i -: 8], ack);
      acks[i+1] = ack;
    end
  endtask

  // Frame-level reference: a write to 0x42 is acked for up to 13 data bytes, and a frame is
  // good only with exactly 13 bytes and a 111111 header.
  function automatic void model(inout vec_t v);
    bit addr_ok = (v.addr == 8'h84);
    bit good;
    v.exp_ack = '0;
    for (int i = 0; i <= v.n; i++) v.exp_ack[i] = addr_ok && (i <= 13);
    good = addr_ok && (v.n == 13) && (v.d[127:122] == 6'h3F);
    v.exp_valid = good;
    v.exp_err = addr_ok && !good;
  endfunction

  function automatic logic [127:0] outs();
    return {30'd0, opcode, a, b, result};
  endfunction

  function automatic logic [127:0] ref_outs();
    return {30'd0, ref_frame[97:96], ref_frame[95:64], ref_frame[63:32], ref_frame[31:0]};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] t1, t_bad, t_long, d;
    logic [31:0]  r;
    logic [15:0]  acks;
    logic [7:0]   hdr;
    bit           ack;
    vec_t         v;

    t1     = {8'hFC, 32'h3F800000, 32'h40000000, 32'h40400000, 24'h0};
    t_bad  = {8'hF8, 32'h3F800000, 32'h40000000, 32'h40400000, 24'h0};
    t_long = {8'hFC, 32'h3F800000, 32'h40000000, 32'h40400000, 8'h55, 16'h0};

    tbl[0] = '{8'h84, 13, t1,     16'h3FFF, 1'b1, 1'b0};
    tbl[1] = '{8'h86, 2,  t1,     16'h0000, 1'b0, 1'b0};
    tbl[2] = '{8'h85, 2,  t1,     16'h0000, 1'b0, 1'b0};
    tbl[3] = '{8'h84, 13, t_bad,  16'h3FFF, 1'b0, 1'b1};
    tbl[4] = '{8'h84, 12, t1,     16'h1FFF, 1'b0, 1'b1};
    tbl[5] = '{8'h84, 14, t_long, 16'h3FFF, 1'b0, 1'b1};
    tbl[6] = '{8'h84, 0,  t1,     16'h0001, 1'b0, 1'b1};
    ntbl = 7;

    for (int k = 0; k < 12; k++) begin
      v.addr = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'h84;
      case ($urandom_range(0, 3))
        0, 1:    v.n = 13;
        2:       v.n = $urandom_range(0, 15);
        default: v.n = ($urandom_range(0, 1) == 0) ? 12 : 14;
      endcase
      hdr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                         : {6'h3F, 2'($urandom_range(0, 3))};
      d = '0;
      d[127:120] = hdr;
      r = $urandom;
      d[119:96] = r[23:0];
      d[95:64] = $urandom;
      d[63:32] = $urandom;
      d[31:0] = $urandom;
      v.d = d;
      model(v);
      tbl[ntbl] = v;
      ntbl++;
    end

    both_cnt = 0;
    clear_mon();
    wt(3);
    check("reset_outputs", {outs(), 32'd0} | 128'(frame_valid) | 128'(frame_err) | 128'(busy), '0);
    check("reset_sda_released", 128'(sda), 128'd1);
    reset_n = 1'b1;
    wt(10);

    for (int k = 0; k < ntbl; k++) begin
      clear_mon();
      send_frame(tbl[k], acks);
      bus_stop();
      if (tbl[k].exp_valid) ref_frame = tbl[k].d[127:24];
      check($sformatf("v%0d_acks", k), 128'(acks), 128'(tbl[k].exp_ack));
      check($sformatf("v%0d_valid", k), 128'(valid_cnt), 128'(tbl[k].exp_valid));
      check($sformatf("v%0d_err", k), 128'(err_cnt), 128'(tbl[k].exp_err));
      check($sformatf("v%0d_outputs", k), outs(), ref_outs());
      check($sformatf("v%0d_busy_end", k), 128'(busy), 128'd0);
      if (tbl[k].exp_valid)
        check($sformatf("v%0d_latency", k), 128'(first_valid - stop_cyc), 128'(SYNC + 2));
      if (tbl[k].addr != 8'h84) begin
        check($sformatf("v%0d_no_drive", k), 128'(dut_low_seen), 128'd0);
        check($sformatf("v%0d_no_busy", k), 128'(busy_seen), 128'd0);
      end else begin
        check($sformatf("v%0d_busy_seen", k), 128'(busy_seen), 128'd1);
      end
      if (k == 0)
        check("t1_values", outs(), {30'd0, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000});
    end

    // Repeated START after five bytes, then the good frame.
    clear_mon();
    bus_start();
    send_byte(8'h84, ack);
    for (int i = 0; i < 5; i++) send_byte(t1[127-8*i -: 8], ack);
    check("rs_busy_before", 128'(busy), 128'd1);
    send_frame(tbl[0], acks);
    check("rs_err_at_restart", 128'(err_cnt), 128'd1);
    check("rs_no_early_valid", 128'(valid_cnt), 128'd0);
    bus_stop();
    check("rs_valid", 128'(valid_cnt), 128'd1);
    check("rs_acks", 128'(acks), 128'h3FFF);
    check("rs_outputs", outs(), {30'd0, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000});

    // Reset while the target is acking byte 3.
    bus_start();
    send_byte(8'h84, ack);
    send_byte(t1[127:120], ack);
    send_byte(t1[119:112], ack);
    for (int i = 7; i >= 0; i--) send_bit(t1[104+i]);
    m_low = 1'b0;
    wt(5);
    scl = 1'b1;
    wt(4);
    check("rst_ack3_driven", 128'(sda), 128'd0);
    reset_n = 1'b0;
    #1;
    check("rst_sda_released", 128'(sda), 128'd1);
    check("rst_outputs_zero", outs() | 128'(frame_valid) | 128'(frame_err) | 128'(busy), '0);
    wt(3);
    reset_n = 1'b1;
    wt(4);
    scl = 1'b0;
    wt(5);
    bus_stop();
    clear_mon();
    send_frame(tbl[0], acks);
    bus_stop();
    check("rst_next_acks", 128'(acks), 128'h3FFF);
    check("rst_next_valid", 128'(valid_cnt), 128'd1);
    check("rst_next_err", 128'(err_cnt), 128'd0);
    check("rst_next_outputs", outs(), {30'd0, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000});
    check("valid_err_exclusive", 128'(both_cnt), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
